// File: rtl/gpio_cmd_ctrl.sv
// Command controller between the processor GPIO words and board I/O: decodes gpo commands,
// runs the enable/ack handshake, and owns the register file, LED drive and switch select.
module gpio_cmd_ctrl #(
    parameter int NB_GPIOS = 32,
    parameter int NB_REG   = 8,
    parameter int NB_LEDS  = 4
) (
    input  logic                clockdsp,
    input  logic                in_reset_n,
    input  logic [NB_GPIOS-1:0] i_gpo,
    output logic [NB_GPIOS-1:0] o_gpi,
    input  logic [3:0]          i_sw,
    input  logic [3:0]          i_vio,
    input  logic                i_from_hard,
    output logic [11:0]         o_leds_rgb,
    output logic [NB_LEDS-3:0]  o_leds
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [6:0] OP_WR     = 7'h01;
    localparam logic [6:0] OP_RD     = 7'h02;
    localparam logic [6:0] OP_SETLED = 7'h03;
    localparam logic [6:0] OP_SWSEL  = 7'h04;
    localparam logic [6:0] OP_RDSW   = 7'h05;
    localparam logic [6:0] OP_CLR    = 7'h06;

    localparam logic [4:0] NB_REG_W  = 5'(NB_REG);

    state_t               state;
    logic [NB_GPIOS-1:0]  r_gpo;
    logic                 en_prev;
    logic                 rise;
    logic [6:0]           cmd_op;
    logic [3:0]           cmd_addr;
    logic [15:0]          cmd_wdata;
    logic                 ack;
    logic                 err;
    logic [7:0]           cmd_count;
    logic [15:0]          rdata;
    logic [11:0]          rgb;
    logic [NB_LEDS-3:0]   leds;
    logic [1:0]           sel;
    logic [3:0]           sel_sw;
    logic                 addr_ok;
    logic [15:0]          reg_file [0:15];

    // The reserved command bits carry no meaning for this block.
    logic unused_reserved;
    assign unused_reserved = ^r_gpo[19:16];

    always_ff @(posedge clockdsp or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_gpo   <= '0;
            en_prev <= 1'b0;
            rise    <= 1'b0;
        end else begin
            r_gpo   <= i_gpo;
            en_prev <= r_gpo[31];
            rise    <= r_gpo[31] & ~en_prev;
        end
    end

    always_comb begin
        sel_sw = i_from_hard ? i_sw : i_vio;
        case (sel)
            2'd1:    sel_sw = i_sw;
            2'd2:    sel_sw = i_vio;
            default: sel_sw = i_from_hard ? i_sw : i_vio;
        endcase
    end

    assign addr_ok = ({1'b0, cmd_addr} < NB_REG_W);

    // Only entries below NB_REG are ever written; the rest stay at their reset value.
    always_ff @(posedge clockdsp or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state     <= IDLE;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            cmd_count <= '0;
            rdata     <= '0;
            rgb       <= '0;
            leds      <= '0;
            sel       <= '0;
            for (int i = 0; i < 16; i++) reg_file[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        cmd_op    <= r_gpo[30:24];
                        cmd_addr  <= r_gpo[23:20];
                        cmd_wdata <= r_gpo[15:0];
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    ack       <= 1'b1;
                    err       <= 1'b0;
                    cmd_count <= cmd_count + 8'd1;
                    state     <= ACK;
                    case (cmd_op)
                        OP_WR: begin
                            if (addr_ok) reg_file[cmd_addr] <= cmd_wdata;
                            else         err <= 1'b1;
                        end
                        OP_RD: begin
                            if (addr_ok) begin
                                rdata <= reg_file[cmd_addr];
                            end else begin
                                rdata <= '0;
                                err   <= 1'b1;
                            end
                        end
                        OP_SETLED: begin
                            rgb  <= cmd_wdata[11:0];
                            leds <= cmd_wdata[13:12];
                        end
                        OP_SWSEL: begin
                            if (cmd_wdata[1:0] == 2'd3) err <= 1'b1;
                            else                        sel <= cmd_wdata[1:0];
                        end
                        OP_RDSW: rdata <= {12'b0, sel_sw};
                        OP_CLR: begin
                            cmd_count <= '0;
                            rgb       <= '0;
                            leds      <= '0;
                            sel       <= '0;
                            for (int i = 0; i < 16; i++) reg_file[i] <= '0;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                ACK: begin
                    if (!r_gpo[31]) begin
                        ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_gpi      = {ack, err, 6'b0, cmd_count, rdata};
    assign o_leds_rgb = rgb;
    assign o_leds     = leds;

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Bench for gpio_cmd_ctrl: randomized and directed commands compared against a
// behavioural model of the command set and handshake timing.
module tb_gpio_cmd_ctrl;

    localparam int NB_REG = 8;

    logic        clockdsp = 1'b0;
    logic        in_reset_n = 1'b0;
    logic [31:0] i_gpo = '0;
    logic [31:0] o_gpi;
    logic [3:0]  i_sw = '0;
    logic [3:0]  i_vio = '0;
    logic        i_from_hard = 1'b0;
    logic [11:0] o_leds_rgb;
    logic [1:0]  o_leds;

    int tests_run = 0;
    int failures  = 0;

    logic [15:0] m_regs [16];
    logic [11:0] m_rgb;
    logic [1:0]  m_leds;
    logic [1:0]  m_sel;
    int          m_count;
    logic [15:0] m_rdata;
    logic        m_err;

    gpio_cmd_ctrl #(.NB_GPIOS(32), .NB_REG(NB_REG), .NB_LEDS(4)) dut (
        .clockdsp    (clockdsp),
        .in_reset_n  (in_reset_n),
        .i_gpo       (i_gpo),
        .o_gpi       (o_gpi),
        .i_sw        (i_sw),
        .i_vio       (i_vio),
        .i_from_hard (i_from_hard),
        .o_leds_rgb  (o_leds_rgb),
        .o_leds      (o_leds)
    );

    always #5 clockdsp = ~clockdsp;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_rgb = '0; m_leds = '0; m_sel = '0; m_count = 0; m_rdata = '0; m_err = 1'b0;
    endfunction

    function automatic logic [3:0] model_switches();
        if (m_sel == 2'd1) return i_sw;
        if (m_sel == 2'd2) return i_vio;
        return i_from_hard ? i_sw : i_vio;
    endfunction

    function automatic void model_cmd(input logic [6:0] op, input logic [3:0] addr, input logic [15:0] wdata);
        m_err = 1'b0;
        case (op)
            7'h01: if (addr < NB_REG) m_regs[addr] = wdata; else m_err = 1'b1;
            7'h02: if (addr < NB_REG) m_rdata = m_regs[addr];
                   else begin m_rdata = '0; m_err = 1'b1; end
            7'h03: begin m_rgb = wdata[11:0]; m_leds = wdata[13:12]; end
            7'h04: if (wdata[1:0] == 2'd3) m_err = 1'b1; else m_sel = wdata[1:0];
            7'h05: m_rdata = {12'b0, model_switches()};
            7'h06: begin
                for (int i = 0; i < 16; i++) m_regs[i] = '0;
                m_rgb = '0; m_leds = '0; m_sel = '0;
            end
            default: m_err = 1'b1;
        endcase
        m_count = (op == 7'h06) ? 0 : (m_count + 1) % 256;
    endfunction

    function automatic logic [31:0] exp_gpi(input logic ack);
        return {ack, m_err, 6'b0, 8'(m_count), m_rdata};
    endfunction

    // Raises enable with a fresh command; lat is the edge count after the sampling edge.
    task automatic send_cmd(input logic [6:0] op, input logic [3:0] addr, input logic [15:0] wdata,
                            output int lat, output logic [31:0] gpi);
        @(negedge clockdsp);
        i_gpo = {1'b1, op, addr, 4'($urandom_range(0, 15)), wdata};
        model_cmd(op, addr, wdata);
        lat = -1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clockdsp); #1;
            if (o_gpi[31]) begin lat = n; break; end
        end
        gpi = o_gpi;
    endtask

    task automatic release_en(output int cyc);
        @(negedge clockdsp);
        i_gpo[31] = 1'b0;
        cyc = -1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clockdsp); #1;
            if (!o_gpi[31]) begin cyc = n; break; end
        end
    endtask

    task automatic test_reset();
        in_reset_n = 1'b0;
        i_gpo = '0;
        model_reset();
        repeat (3) @(posedge clockdsp);
        #1;
        tests_run++;
        if ({o_gpi, o_leds_rgb, o_leds} !== 46'h0) begin
            failures++;
            $display("[TB] FAIL reset_hold got gpi=%h rgb=%h leds=%b want all 0", o_gpi, o_leds_rgb, o_leds);
        end
        @(negedge clockdsp);
        in_reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clockdsp);
            tests_run++;
            if ({o_gpi, o_leds_rgb, o_leds} !== 46'h0) begin
                failures++;
                $display("[TB] FAIL idle_cycle%0d got gpi=%h rgb=%h leds=%b want all 0", c, o_gpi, o_leds_rgb, o_leds);
            end
        end
    endtask

    task automatic test_wr_rd();
        int lat, cyc;
        logic [31:0] gpi;
        send_cmd(7'h01, 4'd3, 16'hBEEF, lat, gpi);
        tests_run++;
        if (lat !== 3) begin failures++; $display("[TB] FAIL wr_latency got %0d want 3", lat); end
        tests_run++;
        if (gpi !== exp_gpi(1'b1)) begin failures++; $display("[TB] FAIL wr_gpi got %h want %h", gpi, exp_gpi(1'b1)); end
        release_en(cyc);
        tests_run++;
        if (cyc !== 1 || o_gpi !== exp_gpi(1'b0)) begin
            failures++;
            $display("[TB] FAIL wr_release got cyc=%0d gpi=%h want cyc=1 gpi=%h", cyc, o_gpi, exp_gpi(1'b0));
        end
        send_cmd(7'h02, 4'd3, 16'h0000, lat, gpi);
        tests_run++;
        if (lat !== 3 || gpi !== 32'h8002BEEF) begin
            failures++;
            $display("[TB] FAIL rd_beef got lat=%0d gpi=%h want lat=3 gpi=8002beef", lat, gpi);
        end
        release_en(cyc);
    endtask

    task automatic test_errors();
        int lat, cyc;
        logic [31:0] gpi;
        send_cmd(7'h01, 4'(NB_REG), 16'h5555, lat, gpi);
        tests_run++;
        if (gpi[31:30] !== 2'b11 || gpi !== exp_gpi(1'b1)) begin
            failures++;
            $display("[TB] FAIL wr_oob got %h want %h", gpi, exp_gpi(1'b1));
        end
        release_en(cyc);
        send_cmd(7'h02, 4'd3, 16'h0, lat, gpi);
        tests_run++;
        if (gpi !== exp_gpi(1'b1) || gpi[15:0] !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL rd_after_oob got %h want %h", gpi, exp_gpi(1'b1));
        end
        release_en(cyc);
        send_cmd(7'h7F, 4'd0, 16'h0, lat, gpi);
        tests_run++;
        if (gpi[30] !== 1'b1 || gpi !== exp_gpi(1'b1)) begin
            failures++;
            $display("[TB] FAIL bad_opcode got %h want %h", gpi, exp_gpi(1'b1));
        end
        release_en(cyc);
        send_cmd(7'h02, 4'd12, 16'h0, lat, gpi);
        tests_run++;
        if (gpi !== exp_gpi(1'b1) || gpi[15:0] !== 16'h0) begin
            failures++;
            $display("[TB] FAIL rd_oob got %h want %h", gpi, exp_gpi(1'b1));
        end
        release_en(cyc);
    endtask

    task automatic test_set_led_hold();
        int lat, cyc;
        logic [31:0] gpi;
        send_cmd(7'h03, 4'd0, 16'h2A5C, lat, gpi);
        tests_run++;
        if (o_leds_rgb !== 12'hA5C || o_leds !== 2'b10) begin
            failures++;
            $display("[TB] FAIL set_led got rgb=%h leds=%b want a5c 10", o_leds_rgb, o_leds);
        end
        repeat (20) @(posedge clockdsp);
        #1;
        tests_run++;
        if (o_gpi !== exp_gpi(1'b1)) begin
            failures++;
            $display("[TB] FAIL hold_single got %h want %h", o_gpi, exp_gpi(1'b1));
        end
        release_en(cyc);
    endtask

    task automatic test_sw_sel();
        int lat, cyc;
        logic [31:0] gpi;
        i_from_hard = 1'b0; i_vio = 4'h9; i_sw = 4'h6;
        send_cmd(7'h04, 4'd0, 16'h0000, lat, gpi); release_en(cyc);
        send_cmd(7'h05, 4'd0, 16'h0000, lat, gpi); release_en(cyc);
        tests_run++;
        if (gpi[15:0] !== 16'h0009 || gpi !== exp_gpi(1'b1)) begin
            failures++;
            $display("[TB] FAIL rdsw_auto got %h want rdata 0009 (%h)", gpi, exp_gpi(1'b1));
        end
        send_cmd(7'h04, 4'd0, 16'h0001, lat, gpi); release_en(cyc);
        send_cmd(7'h05, 4'd0, 16'h0000, lat, gpi); release_en(cyc);
        tests_run++;
        if (gpi[15:0] !== 16'h0006) begin
            failures++;
            $display("[TB] FAIL rdsw_force_sw got %h want rdata 0006", gpi);
        end
        send_cmd(7'h04, 4'd0, 16'h0003, lat, gpi); release_en(cyc);
        tests_run++;
        if (gpi[30] !== 1'b1) begin failures++; $display("[TB] FAIL swsel3_err got %h want err=1", gpi); end
        send_cmd(7'h05, 4'd0, 16'h0000, lat, gpi); release_en(cyc);
        tests_run++;
        if (gpi[15:0] !== 16'h0006 || gpi !== exp_gpi(1'b1)) begin
            failures++;
            $display("[TB] FAIL swsel3_keep got %h want %h", gpi, exp_gpi(1'b1));
        end
    endtask

    // One-cycle enable pulses: the command completes and ack shows for exactly one cycle.
    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            logic [6:0]  op;
            logic [3:0]  addr;
            logic [15:0] wdata;
            op = (t % 2 == 0) ? 7'h01 : 7'h02;
            addr = 4'(t / 2);
            wdata = 16'($urandom);
            @(negedge clockdsp);
            i_gpo = {1'b1, op, addr, 4'h0, wdata};
            model_cmd(op, addr, wdata);
            @(negedge clockdsp);
            i_gpo[31] = 1'b0;
            repeat (2) @(posedge clockdsp);
            @(posedge clockdsp); #1;
            tests_run++;
            if (o_gpi !== exp_gpi(1'b1)) begin
                failures++;
                $display("[TB] FAIL b2b_ack%0d got %h want %h", t, o_gpi, exp_gpi(1'b1));
            end
            @(posedge clockdsp); #1;
            tests_run++;
            if (o_gpi !== exp_gpi(1'b0)) begin
                failures++;
                $display("[TB] FAIL b2b_drop%0d got %h want %h", t, o_gpi, exp_gpi(1'b0));
            end
        end
    endtask

    task automatic test_random();
        int lat, cyc;
        logic [31:0] gpi;
        logic [6:0] ops [8] = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h00, 7'h7F};
        for (int t = 0; t < 40; t++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 7)];
            @(negedge clockdsp);
            i_sw = 4'($urandom); i_vio = 4'($urandom); i_from_hard = 1'($urandom);
            send_cmd(op, 4'($urandom_range(0, 10)), 16'($urandom), lat, gpi);
            tests_run++;
            if (lat !== 3 || gpi !== exp_gpi(1'b1) || o_leds_rgb !== m_rgb || o_leds !== m_leds) begin
                failures++;
                $display("[TB] FAIL rand%0d op=%h got lat=%0d gpi=%h rgb=%h leds=%b want lat=3 gpi=%h rgb=%h leds=%b",
                         t, op, lat, gpi, o_leds_rgb, o_leds, exp_gpi(1'b1), m_rgb, m_leds);
            end
            release_en(cyc);
        end
    endtask

    task automatic test_count_wrap();
        int lat, cyc;
        logic [31:0] gpi;
        send_cmd(7'h06, 4'd0, 16'h0, lat, gpi); release_en(cyc);
        tests_run++;
        if (gpi[23:16] !== 8'h00 || gpi !== exp_gpi(1'b1)) begin
            failures++;
            $display("[TB] FAIL clr got %h want %h", gpi, exp_gpi(1'b1));
        end
        for (int t = 0; t < 256; t++) begin
            send_cmd(7'h01, 4'($urandom_range(0, NB_REG - 1)), 16'($urandom), lat, gpi);
            release_en(cyc);
        end
        send_cmd(7'h02, 4'd1, 16'h0, lat, gpi); release_en(cyc);
        tests_run++;
        if (gpi[23:16] !== 8'h01 || gpi !== exp_gpi(1'b1)) begin
            failures++;
            $display("[TB] FAIL count_wrap got %h want %h", gpi, exp_gpi(1'b1));
        end
    endtask

    task automatic test_reset_in_exec();
        int lat, cyc;
        logic [31:0] gpi;
        send_cmd(7'h03, 4'd0, 16'h1FFF, lat, gpi); release_en(cyc);
        @(negedge clockdsp);
        i_gpo = {1'b1, 7'h01, 4'd5, 4'h0, 16'h1234};
        repeat (3) @(posedge clockdsp);
        #1;
        in_reset_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({o_gpi, o_leds_rgb, o_leds} !== 46'h0) begin
            failures++;
            $display("[TB] FAIL reset_exec got gpi=%h rgb=%h leds=%b want all 0", o_gpi, o_leds_rgb, o_leds);
        end
        @(negedge clockdsp);
        i_gpo = '0;
        @(negedge clockdsp);
        in_reset_n = 1'b1;
        send_cmd(7'h02, 4'd5, 16'h0, lat, gpi); release_en(cyc);
        tests_run++;
        if (gpi !== 32'h80010000) begin
            failures++;
            $display("[TB] FAIL reset_exec_nowrite got %h want 80010000", gpi);
        end
    endtask

    initial begin
        test_reset();
        test_wr_rd();
        test_errors();
        test_set_led_hold();
        test_sw_sel();
        test_back_to_back();
        test_random();
        test_count_wrap();
        test_reset_in_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
